// File: rtl/core_lsu.sv
// Load/store unit: alignment check, byte-lane steering and a
// req/gnt/rvalid memory handshake in front of the extension stage.
module core_lsu #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic              i_lsu_we,
  input  logic              i_lsu_su_extend,
  input  logic [1:0]        i_lsu_r_w_size,
  input  logic [ADDR_W-1:0] i_lsu_addr,
  input  logic [XLEN-1:0]   i_lsu_wdata,
  output logic              o_lsu_done,
  output logic [XLEN-1:0]   o_lsu_rdata,
  output logic [1:0]        o_lsu_r_w_size,
  output logic              o_lsu_su_extend,
  output logic              o_lsu_misaligned,
  output logic              o_lsu_busy,
  output logic              o_mem_req,
  input  logic              i_mem_gnt,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [XLEN/8-1:0] o_mem_be,
  output logic [XLEN-1:0]   o_mem_wdata,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t              r_state;
  logic                r_we;
  logic                r_su;
  logic [1:0]          r_size;
  logic [2:0]          r_off;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [XLEN/8-1:0]   r_mem_be;
  logic [XLEN-1:0]     r_mem_wdata;
  logic                r_done;
  logic                r_mis;
  logic [XLEN-1:0]     r_rdata;
  logic [1:0]          r_out_size;
  logic                r_out_su;

  logic [2:0]          w_off;
  logic                w_mis;
  logic [XLEN/8-1:0]   w_be_base;
  logic [XLEN/8-1:0]   w_be;
  logic [XLEN-1:0]     w_wdata;
  logic [XLEN-1:0]     w_rdata;
  logic [ADDR_W-1:0]   w_addr;

  assign w_off = i_lsu_addr[2:0];

  // Natural alignment: off must be a multiple of the access size
  always_comb begin
    w_mis     = 1'b0;
    w_be_base = '0;
    unique case (i_lsu_r_w_size)
      2'b00: begin
        w_mis     = 1'b0;
        w_be_base = 8'h01;
      end
      2'b01: begin
        w_mis     = w_off[0];
        w_be_base = 8'h03;
      end
      2'b10: begin
        w_mis     = |w_off[1:0];
        w_be_base = 8'h0F;
      end
      2'b11: begin
        w_mis     = |w_off;
        w_be_base = 8'hFF;
      end
    endcase
  end

  assign w_be    = w_be_base << w_off;
  assign w_wdata = i_lsu_we ? (i_lsu_wdata << {w_off, 3'b000})
                            : '0;
  assign w_rdata = i_mem_rdata >> {r_off, 3'b000};
  assign w_addr  = {i_lsu_addr[ADDR_W-1:3], 3'b000};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_su        <= 1'b0;
      r_size      <= 2'b00;
      r_off       <= 3'b000;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_mis       <= 1'b0;
      r_rdata     <= '0;
      r_out_size  <= 2'b00;
      r_out_su    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_mis  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_lsu_valid) begin
            if (w_mis) begin
              r_mis <= 1'b1;
            end else begin
              r_we        <= i_lsu_we;
              r_su        <= i_lsu_su_extend;
              r_size      <= i_lsu_r_w_size;
              r_off       <= w_off;
              r_mem_req   <= 1'b1;
              r_mem_we    <= i_lsu_we;
              r_mem_addr  <= w_addr;
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_mem_rvalid) begin
            r_done     <= 1'b1;
            r_rdata    <= r_we ? '0 : w_rdata;
            r_out_size <= r_size;
            r_out_su   <= r_su;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_lsu_ready      = (r_state == S_IDLE);
  assign o_lsu_busy       = (r_state != S_IDLE);
  assign o_lsu_done       = r_done;
  assign o_lsu_rdata      = r_rdata;
  assign o_lsu_r_w_size   = r_out_size;
  assign o_lsu_su_extend  = r_out_su;
  assign o_lsu_misaligned = r_mis;
  assign o_mem_req        = r_mem_req;
  assign o_mem_we         = r_mem_we;
  assign o_mem_addr       = r_mem_addr;
  assign o_mem_be         = r_mem_be;
  assign o_mem_wdata      = r_mem_wdata;

endmodule
